cp0_exc_ctrl: RTL and testbench
===============================

# cp0_exc_ctrl

Parametrised CP0 exception controller for the pipelined FPU/cache/TLB CPU. It holds the Status, Cause and EPC registers and arbitrates six synchronous exception sources plus NIRQ masked external interrupts. It keeps an EPC/Status stack so handlers can nest, and it drives cancel and PC-select to the pipeline. It sits beside the decode-stage control unit, which supplies mtc0/mfc0/eret decodes and per-stage exception flags.

## Interface
Parameters:
- NIRQ, 4: external interrupt lines, 1..16.
- DEPTH, 2: nesting stack entries, 1..8.
- EXC_VEC, 32'h0000_0008: exception handler address.

Ports:
- clk  in  1  clock; all registers rise-edge.
- rst  in  1  asynchronous, active-high reset.
- irq  in  NIRQ  level-sensitive interrupt requests.
- dtlb_exc, ovr_exc, unimpl_exc, sys_exc, itlb_exc  in  1 each  exception flags from MEM, EXE, ID, ID and IF respectively.
- ecancel  in  1  ID instruction already cancelled.
- pc_f, pc_d, pc_e, pc_m, pc_w  in  32 each  stage PCs.
- bd_f, bd_d, bd_e, bd_m  in  1 each  stage instruction is in a branch delay slot.
- wc0  in  1  mtc0 strobe.
- rc0_n  in  5  mfc0 register number.
- wc0_n  in  5  mtc0 register number.
- wc0_d  in  32  mtc0 data.
- eret  in  1  eret decoded in ID.
- exce  out  1  exception taken this cycle.
- cancel  out  1  equals exce.
- selpc  out  2  00 sequential, 01 EPC, 10 EXC_VEC.
- epc_o  out  32  current EPC.
- sta_o, cau_o  out  32  Status, Cause.
- c0_rdata  out  32  mfc0 read data.
- depth  out  4  stack occupancy.

## Operation
- Status:
  - bit0 IE (interrupt enable).
  - bits[5:1] enables for sys, unimpl, ovr, itlb, dtlb.
  - bits[8+:NIRQ] IRQ mask.
  - Other bits read 0.
- Cause:
  - bit31 BD.
  - bit30 OVF (sticky stack overflow).
  - bits[8+:NIRQ] IP (pending interrupts, live).
  - bits[4:2] exccode: 0 irq, 1 sys, 2 unimpl, 3 ovr, 4 itlb, 5 dtlb.
  - Other bits read 0.
- A source is eligible when its flag is set and its Status enable bit is set.
  - ID-stage sources (sys, unimpl, irq) are additionally gated by ~ecancel.
  - irq is eligible when IE=1 and |(irq_s & mask), where irq_s is the (optionally synchronised) irq.
- Priority, oldest instruction first: dtlb > ovr > unimpl > sys > irq > itlb.
- EPC of the winner is computed from its stage PC. If that stage's bd flag is set, EPC is the next-older stage PC instead (IF→pc_d, ID→pc_e, EXE→pc_m, MEM→pc_w), and Cause.BD=1.
- When an exception is taken:
  - Push {Status, EPC} onto the stack.
  - Status[5:0] ← 0.
  - EPC ← computed EPC.
  - Cause exccode and BD ← winner's values.
  - selpc=10.
- Stack full on exception: discard the oldest entry, push the new one, set Cause.OVF. depth stays at DEPTH.
- eret without an exception:
  - selpc=01; epc_o holds the return address this cycle.
  - At the clock edge, pop {Status, EPC} and decrement depth.
  - If depth=0, Status and EPC are unchanged and only selpc is driven.
- mtc0:
  - reg 12 writes Status.
  - reg 13 writes only OVF (wc0_d[30]).
  - reg 14 writes EPC.
  - Other numbers are ignored.
- mfc0: rc0_n 12/13/14 returns Status/Cause/EPC; any other number returns 0. Read is combinational.

## Timing
- exce, cancel, selpc and c0_rdata are combinational in the cycle the condition is present.
- Register updates happen at the end of that cycle; mfc0 sees them from the next cycle.
- Simultaneous events:
  - Exception + eret: exception wins and no pop occurs.
  - Exception + mtc0: mtc0 is dropped.
  - eret + mtc0: mtc0 applies first, then the pop overwrites the targeted register.
- Reset (async, any time, including mid-handler): Status=0, Cause=0, EPC=0, stack cleared, depth=0, sync flops=0.
- Outputs after reset: exce=0, selpc=00, sta_o=cau_o=epc_o=0, depth=0.

## Configuration
- CP0_IRQ_SYNC_EN defined: each irq passes a 2-flop synchroniser (reset 0), so interrupt-to-exce latency is 2 cycles.
- CP0_IRQ_SYNC_EN undefined: irq_s=irq, same-cycle eligibility, 0-cycle latency.
- Cause.IP reflects irq_s in both builds.

## Test plan
- Reset, then Status=32'h3F, dtlb_exc=1 and itlb_exc=1 in the same cycle, bd_m=0, pc_m=32'h100 → exce=1, selpc=10, next cycle Cause[4:2]=5, EPC=32'h100, Status[5:0]=0, depth=1.
- Status=32'h3F, itlb_exc=1 with bd_f=1, pc_d=32'h200 → EPC=32'h200, Cause.BD=1, exccode=4.
- NIRQ=4, Status=32'h0000_0101, irq=4'b0001 → with CP0_IRQ_SYNC_EN, exce is first asserted 2 cycles later; with ecancel=1, exce=0.
- DEPTH=2: three nested exceptions, each handler re-enabling via mtc0 Status=32'h3F → depth=2, OVF=1. Then two erets restore Status/EPC of exceptions 2 then 1. A third eret gives selpc=01 with registers unchanged.
- eret with ovr_exc eligible in the same cycle → selpc=10, depth increments, no pop.
- Assert rst mid-handler with depth=1 → all registers 0 immediately, depth=0, exce=0.

Source files
------------

// File: rtl/cp0_exc_ctrl_if.sv
// CP0 exception controller bus: pipeline-side signals grouped
// into one bundle; the controller takes the slave view.
interface cp0_exc_ctrl_if #(
  parameter int NIRQ = 4
);
  logic [NIRQ-1:0] irq;
  logic            dtlb_exc;
  logic            ovr_exc;
  logic            unimpl_exc;
  logic            sys_exc;
  logic            itlb_exc;
  logic            ecancel;
  logic [31:0]     pc_f;
  logic [31:0]     pc_d;
  logic [31:0]     pc_e;
  logic [31:0]     pc_m;
  logic [31:0]     pc_w;
  logic            bd_f;
  logic            bd_d;
  logic            bd_e;
  logic            bd_m;
  logic            wc0;
  logic [4:0]      rc0_n;
  logic [4:0]      wc0_n;
  logic [31:0]     wc0_d;
  logic            eret;
  logic            exce;
  logic            cancel;
  logic [1:0]      selpc;
  logic [31:0]     epc_o;
  logic [31:0]     sta_o;
  logic [31:0]     cau_o;
  logic [31:0]     c0_rdata;
  logic [3:0]      depth;

  modport master (
    output irq, dtlb_exc, ovr_exc, unimpl_exc, sys_exc,
    output itlb_exc, ecancel,
    output pc_f, pc_d, pc_e, pc_m, pc_w,
    output bd_f, bd_d, bd_e, bd_m,
    output wc0, rc0_n, wc0_n, wc0_d, eret,
    input  exce, cancel, selpc, epc_o, sta_o, cau_o,
    input  c0_rdata, depth
  );

  modport slave (
    input  irq, dtlb_exc, ovr_exc, unimpl_exc, sys_exc,
    input  itlb_exc, ecancel,
    input  pc_f, pc_d, pc_e, pc_m, pc_w,
    input  bd_f, bd_d, bd_e, bd_m,
    input  wc0, rc0_n, wc0_n, wc0_d, eret,
    output exce, cancel, selpc, epc_o, sta_o, cau_o,
    output c0_rdata, depth
  );
endinterface

// File: rtl/cp0_exc_ctrl.sv
// CP0 exception controller: Status/Cause/EPC, priority arbiter
// and nesting stack. Define CP0_IRQ_SYNC_EN for 2-flop irq sync.
module cp0_exc_ctrl #(
  parameter int          NIRQ    = 4,
  parameter int          DEPTH   = 2,
  parameter logic [31:0] EXC_VEC = 32'h0000_0008
) (
  input logic       clk,
  input logic       rst,
  cp0_exc_ctrl_if.slave bus
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] DMAX = 4'(DEPTH);
  localparam logic [31:0] IRQ_BITS =
    ((32'h1 << NIRQ) - 32'h1) << 8;
  localparam logic [31:0] STA_MASK = 32'h3F | IRQ_BITS;

  logic [31:0]     sta;
  logic [31:0]     epc;
  logic            bd;
  logic            ovf;
  logic [2:0]      code;
  logic [3:0]      dep;
  logic [31:0]     stk_sta [DEPTH];
  logic [31:0]     stk_epc [DEPTH];
  logic [NIRQ-1:0] irq_s;

  logic            e_dtlb;
  logic            e_ovr;
  logic            e_unimpl;
  logic            e_sys;
  logic            e_irq;
  logic            e_itlb;
  logic            take;
  logic [2:0]      w_code;
  logic            w_bd;
  logic [31:0]     w_epc;
  logic [31:0]     cau;
  logic            full;
  logic [3:0]      dm1;
  logic [AW-1:0]   pidx;
  logic [AW-1:0]   tidx;
  logic            unused;

`ifdef CP0_IRQ_SYNC_EN
  logic [NIRQ-1:0] s1;
  logic [NIRQ-1:0] s2;

  // two-flop synchroniser on the raw interrupt lines
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= bus.irq;
      s2 <= s1;
    end
  end

  assign irq_s = s2;
`else
  assign irq_s = bus.irq;
`endif

  assign e_dtlb   = bus.dtlb_exc & sta[5];
  assign e_ovr    = bus.ovr_exc & sta[3];
  assign e_unimpl = bus.unimpl_exc & sta[2] & ~bus.ecancel;
  assign e_sys    = bus.sys_exc & sta[1] & ~bus.ecancel;
  assign e_irq    = sta[0] & (|(irq_s & sta[8 +: NIRQ]))
                  & ~bus.ecancel;
  assign e_itlb   = bus.itlb_exc & sta[4];

  // oldest-stage-first arbitration and EPC/BD selection
  always_comb begin
    take   = 1'b1;
    w_code = 3'd0;
    w_bd   = 1'b0;
    w_epc  = 32'h0;
    if (e_dtlb) begin
      w_code = 3'd5;
      w_bd   = bus.bd_m;
      w_epc  = bus.bd_m ? bus.pc_w : bus.pc_m;
    end else if (e_ovr) begin
      w_code = 3'd3;
      w_bd   = bus.bd_e;
      w_epc  = bus.bd_e ? bus.pc_m : bus.pc_e;
    end else if (e_unimpl) begin
      w_code = 3'd2;
      w_bd   = bus.bd_d;
      w_epc  = bus.bd_d ? bus.pc_e : bus.pc_d;
    end else if (e_sys) begin
      w_code = 3'd1;
      w_bd   = bus.bd_d;
      w_epc  = bus.bd_d ? bus.pc_e : bus.pc_d;
    end else if (e_irq) begin
      w_code = 3'd0;
      w_bd   = bus.bd_d;
      w_epc  = bus.bd_d ? bus.pc_e : bus.pc_d;
    end else if (e_itlb) begin
      w_code = 3'd4;
      w_bd   = bus.bd_f;
      w_epc  = bus.bd_f ? bus.pc_d : bus.pc_f;
    end else begin
      take   = 1'b0;
    end
  end

  // Cause view: IP is live, the rest is registered
  always_comb begin
    cau           = 32'h0;
    cau[31]       = bd;
    cau[30]       = ovf;
    cau[8 +: NIRQ] = irq_s;
    cau[4:2]      = code;
  end

  // combinational mfc0 read port
  always_comb begin
    case (bus.rc0_n)
      5'd12:   bus.c0_rdata = sta;
      5'd13:   bus.c0_rdata = cau;
      5'd14:   bus.c0_rdata = epc;
      default: bus.c0_rdata = 32'h0;
    endcase
  end

  assign full = (dep == DMAX);
  assign dm1  = dep - 4'd1;
  assign pidx = dep[AW-1:0];
  assign tidx = dm1[AW-1:0];

  assign bus.exce   = take;
  assign bus.cancel = take;
  assign bus.selpc  = take ? 2'b10 : (bus.eret ? 2'b01 : 2'b00);
  assign bus.epc_o  = epc;
  assign bus.sta_o  = sta;
  assign bus.cau_o  = cau;
  assign bus.depth  = dep;

  assign unused = ^{EXC_VEC};

  // exception push, eret pop and mtc0 writes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sta  <= 32'h0;
      epc  <= 32'h0;
      bd   <= 1'b0;
      ovf  <= 1'b0;
      code <= 3'd0;
      dep  <= 4'd0;
      for (int i = 0; i < DEPTH; i++) begin
        stk_sta[i] <= 32'h0;
        stk_epc[i] <= 32'h0;
      end
    end else if (take) begin
      if (full) begin
        for (int i = 0; i < DEPTH - 1; i++) begin
          stk_sta[i] <= stk_sta[i+1];
          stk_epc[i] <= stk_epc[i+1];
        end
        stk_sta[DEPTH-1] <= sta;
        stk_epc[DEPTH-1] <= epc;
        ovf <= 1'b1;
      end else begin
        stk_sta[pidx] <= sta;
        stk_epc[pidx] <= epc;
        dep <= dep + 4'd1;
      end
      sta  <= {sta[31:6], 6'b0};
      epc  <= w_epc;
      bd   <= w_bd;
      code <= w_code;
    end else begin
      if (bus.wc0) begin
        case (bus.wc0_n)
          5'd12:   sta <= bus.wc0_d & STA_MASK;
          5'd13:   ovf <= bus.wc0_d[30];
          5'd14:   epc <= bus.wc0_d;
          default: ;
        endcase
      end
      if (bus.eret && dep != 4'd0) begin
        sta <= stk_sta[tidx];
        epc <= stk_epc[tidx];
        dep <= dm1;
      end
    end
  end

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// Bench for cp0_exc_ctrl: directed scenarios then random traffic
// checked against a queue-based reference model.
module tb_cp0_exc_ctrl;

  localparam int NIRQ  = 4;
  localparam int DEPTH = 2;
  localparam logic [31:0] SMASK = 32'h0000_0F3F;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  cp0_exc_ctrl_if #(.NIRQ(NIRQ)) bus ();

  cp0_exc_ctrl #(
    .NIRQ(NIRQ),
    .DEPTH(DEPTH),
    .EXC_VEC(32'h0000_0008)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int nchk = 0;
  int nerr = 0;

  logic [31:0]     m_sta;
  logic [31:0]     m_epc;
  logic            m_bd;
  logic            m_ovf;
  logic [2:0]      m_code;
  logic [63:0]     m_stk[$];
  logic [NIRQ-1:0] m_q1;
  logic [NIRQ-1:0] m_q2;

  logic            x_exce;
  logic [1:0]      x_sel;
  logic [31:0]     x_cau;
  logic [31:0]     x_rd;
  logic [31:0]     x_nepc;
  logic            x_nbd;
  logic [2:0]      x_ncode;
  logic [NIRQ-1:0] x_irq_s;
  logic            last_exce;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    nchk++;
    assert (got === exp) else begin
      nerr++;
      $error("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic m_reset();
    m_sta  = 32'h0;
    m_epc  = 32'h0;
    m_bd   = 1'b0;
    m_ovf  = 1'b0;
    m_code = 3'd0;
    m_q1   = '0;
    m_q2   = '0;
    m_stk.delete();
  endtask

  task automatic m_comb();
    bit          en [6];
    logic [2:0]  cd [6];
    logic        b  [6];
    logic [31:0] ep [6];
`ifdef CP0_IRQ_SYNC_EN
    x_irq_s = m_q2;
`else
    x_irq_s = bus.irq;
`endif
    en[0] = bus.dtlb_exc && m_sta[5];
    cd[0] = 3'd5; b[0] = bus.bd_m;
    ep[0] = bus.bd_m ? bus.pc_w : bus.pc_m;
    en[1] = bus.ovr_exc && m_sta[3];
    cd[1] = 3'd3; b[1] = bus.bd_e;
    ep[1] = bus.bd_e ? bus.pc_m : bus.pc_e;
    en[2] = bus.unimpl_exc && m_sta[2] && !bus.ecancel;
    cd[2] = 3'd2; b[2] = bus.bd_d;
    ep[2] = bus.bd_d ? bus.pc_e : bus.pc_d;
    en[3] = bus.sys_exc && m_sta[1] && !bus.ecancel;
    cd[3] = 3'd1; b[3] = bus.bd_d; ep[3] = ep[2];
    en[4] = m_sta[0] && ((x_irq_s & m_sta[11:8]) != 0)
            && !bus.ecancel;
    cd[4] = 3'd0; b[4] = bus.bd_d; ep[4] = ep[2];
    en[5] = bus.itlb_exc && m_sta[4];
    cd[5] = 3'd4; b[5] = bus.bd_f;
    ep[5] = bus.bd_f ? bus.pc_d : bus.pc_f;
    x_exce  = 1'b0;
    x_ncode = 3'd0;
    x_nbd   = 1'b0;
    x_nepc  = 32'h0;
    for (int i = 0; i < 6; i++) begin
      if (en[i] && !x_exce) begin
        x_exce  = 1'b1;
        x_ncode = cd[i];
        x_nbd   = b[i];
        x_nepc  = ep[i];
      end
    end
    x_sel = x_exce ? 2'd2 : (bus.eret ? 2'd1 : 2'd0);
    x_cau = {m_bd, m_ovf, 18'b0, x_irq_s, 3'b0, m_code, 2'b0};
    if (bus.rc0_n == 5'd12)      x_rd = m_sta;
    else if (bus.rc0_n == 5'd13) x_rd = x_cau;
    else if (bus.rc0_n == 5'd14) x_rd = m_epc;
    else                         x_rd = 32'h0;
  endtask

  task automatic check();
    m_comb();
    last_exce = bus.exce;
    chk("exce", {31'b0, bus.exce}, {31'b0, x_exce});
    chk("cancel", {31'b0, bus.cancel}, {31'b0, x_exce});
    chk("selpc", {30'b0, bus.selpc}, {30'b0, x_sel});
    chk("epc", bus.epc_o, m_epc);
    chk("sta", bus.sta_o, m_sta);
    chk("cau", bus.cau_o, x_cau);
    chk("rdata", bus.c0_rdata, x_rd);
    chk("depth", {28'b0, bus.depth}, 32'(m_stk.size()));
  endtask

  task automatic m_next();
    if (rst) begin
      m_reset();
      return;
    end
    if (x_exce) begin
      if (m_stk.size() == DEPTH) begin
        void'(m_stk.pop_front());
        m_ovf = 1'b1;
      end
      m_stk.push_back({m_sta, m_epc});
      m_sta[5:0] = 6'b0;
      m_epc  = x_nepc;
      m_bd   = x_nbd;
      m_code = x_ncode;
    end else begin
      if (bus.wc0) begin
        if (bus.wc0_n == 5'd12) m_sta = bus.wc0_d & SMASK;
        if (bus.wc0_n == 5'd13) m_ovf = bus.wc0_d[30];
        if (bus.wc0_n == 5'd14) m_epc = bus.wc0_d;
      end
      if (bus.eret && m_stk.size() > 0)
        {m_sta, m_epc} = m_stk.pop_back();
    end
    m_q2 = m_q1;
    m_q1 = bus.irq;
  endtask

  task automatic cyc();
    #4;
    check();
    m_next();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.irq = '0;
    bus.dtlb_exc = 0; bus.ovr_exc = 0; bus.unimpl_exc = 0;
    bus.sys_exc = 0; bus.itlb_exc = 0; bus.ecancel = 0;
    bus.bd_f = 0; bus.bd_d = 0; bus.bd_e = 0; bus.bd_m = 0;
    bus.wc0 = 0; bus.wc0_n = 0; bus.wc0_d = 0; bus.eret = 0;
    bus.rc0_n = 5'd13;
  endtask

  task automatic quiet();
    bus.dtlb_exc = 0; bus.ovr_exc = 0; bus.unimpl_exc = 0;
    bus.sys_exc = 0; bus.itlb_exc = 0; bus.ecancel = 0;
    bus.bd_f = 0; bus.bd_d = 0; bus.bd_e = 0; bus.bd_m = 0;
    bus.wc0 = 0; bus.eret = 0;
  endtask

  task automatic mtc0(input logic [4:0] n, input logic [31:0] d);
    quiet();
    bus.wc0 = 1; bus.wc0_n = n; bus.wc0_d = d;
    cyc();
    bus.wc0 = 0;
  endtask

  task automatic do_rst();
    idle();
    #2;
    rst = 1'b1;
    #1;
    m_reset();
    chk("rst_sta", bus.sta_o, 32'h0);
    chk("rst_epc", bus.epc_o, 32'h0);
    chk("rst_cau", bus.cau_o, 32'h0);
    chk("rst_depth", {28'b0, bus.depth}, 32'h0);
    chk("rst_exce", {31'b0, bus.exce}, 32'h0);
    @(posedge clk);
    #1;
    cyc();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int k;
    int exp_lat;
    idle();
    bus.pc_f = 32'h0; bus.pc_d = 32'h0; bus.pc_e = 32'h0;
    bus.pc_m = 32'h0; bus.pc_w = 32'h0;
    rst = 1'b1;
    m_reset();
    @(posedge clk);
    #1;
    cyc();
    chk("reset_sel", {30'b0, bus.selpc}, 32'h0);
    rst = 1'b0;
    cyc();

    mtc0(5'd12, 32'h3F);
    bus.dtlb_exc = 1; bus.itlb_exc = 1;
    bus.pc_m = 32'h100; bus.pc_f = 32'h300; bus.pc_w = 32'hFC;
    #4;
    chk("dtlb_exce", {31'b0, bus.exce}, 32'h1);
    chk("dtlb_sel", {30'b0, bus.selpc}, 32'h2);
    #1;
    @(posedge clk);
    #1;
    m_stk.push_back({32'h3F, 32'h0});
    m_sta = 32'h0; m_epc = 32'h100; m_code = 3'd5; m_bd = 0;
    quiet();
    chk("dtlb_code", {29'b0, bus.cau_o[4:2]}, 32'h5);
    chk("dtlb_epc", bus.epc_o, 32'h100);
    chk("dtlb_sta", {26'b0, bus.sta_o[5:0]}, 32'h0);
    chk("dtlb_depth", {28'b0, bus.depth}, 32'h1);
    cyc();

    mtc0(5'd12, 32'h3F);
    bus.itlb_exc = 1; bus.bd_f = 1;
    bus.pc_d = 32'h200; bus.pc_f = 32'h204;
    cyc();
    quiet();
    chk("itlb_epc", bus.epc_o, 32'h200);
    chk("itlb_bd", {31'b0, bus.cau_o[31]}, 32'h1);
    chk("itlb_code", {29'b0, bus.cau_o[4:2]}, 32'h4);
    bus.eret = 1;
    cyc();
    cyc();
    bus.eret = 0;
    cyc();

    mtc0(5'd12, 32'h101);
    cyc();
    cyc();
`ifdef CP0_IRQ_SYNC_EN
    exp_lat = 2;
`else
    exp_lat = 0;
`endif
    bus.irq = 4'b0001;
    bus.pc_d = 32'h400;
    k = 0;
    while (k < 6) begin
      cyc();
      if (last_exce) break;
      k++;
    end
    chk("irq_lat", 32'(k), 32'(exp_lat));
    bus.ecancel = 1;
    mtc0(5'd12, 32'h101);
    bus.ecancel = 1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("irq_ecancel", {31'b0, last_exce}, 32'h0);
    end
    bus.ecancel = 0;
    cyc();
    bus.irq = '0;
    cyc();
    cyc();

    bus.eret = 1;
    k = 0;
    while (m_stk.size() > 0 && k < 10) begin
      cyc();
      k++;
    end
    bus.eret = 0;
    for (int n = 0; n < 3; n++) begin
      mtc0(5'd12, 32'h3F);
      bus.ovr_exc = 1;
      bus.pc_e = 32'h1000 + 32'(n * 16);
      cyc();
      bus.ovr_exc = 0;
    end
    chk("nest_depth", {28'b0, bus.depth}, 32'h2);
    chk("nest_ovf", {31'b0, bus.cau_o[30]}, 32'h1);
    bus.eret = 1;
    cyc();
    chk("pop1_epc", bus.epc_o, 32'h1010);
    chk("pop1_sta", bus.sta_o, 32'h3F);
    cyc();
    chk("pop2_epc", bus.epc_o, 32'h1000);
    cyc();
    chk("pop3_epc", bus.epc_o, 32'h1000);
    chk("pop3_depth", {28'b0, bus.depth}, 32'h0);
    bus.eret = 0;

    mtc0(5'd12, 32'h3F);
    bus.eret = 1; bus.ovr_exc = 1; bus.pc_e = 32'h2000;
    cyc();
    quiet();
    chk("eret_exc_depth", {28'b0, bus.depth}, 32'h1);
    bus.eret = 1; bus.wc0 = 1; bus.wc0_n = 5'd14;
    bus.wc0_d = 32'hDEAD_0000;
    cyc();
    quiet();
    mtc0(5'd12, 32'h3F);
    bus.sys_exc = 1; bus.pc_d = 32'h3000;
    cyc();
    quiet();
    chk("pre_rst_depth", {28'b0, bus.depth}, 32'h1);
    do_rst();

    for (int t = 0; t < 600; t++) begin
      if ($urandom_range(0, 149) == 0) begin
        do_rst();
        continue;
      end
      if ($urandom_range(0, 3) == 0)
        bus.irq = NIRQ'($urandom);
      bus.dtlb_exc   = ($urandom_range(0, 5) == 0);
      bus.ovr_exc    = ($urandom_range(0, 5) == 0);
      bus.unimpl_exc = ($urandom_range(0, 5) == 0);
      bus.sys_exc    = ($urandom_range(0, 5) == 0);
      bus.itlb_exc   = ($urandom_range(0, 5) == 0);
      bus.ecancel    = ($urandom_range(0, 7) == 0);
      bus.bd_f = 1'($urandom); bus.bd_d = 1'($urandom);
      bus.bd_e = 1'($urandom); bus.bd_m = 1'($urandom);
      bus.pc_f = $urandom & 32'hFFFF_FFFC;
      bus.pc_d = $urandom & 32'hFFFF_FFFC;
      bus.pc_e = $urandom & 32'hFFFF_FFFC;
      bus.pc_m = $urandom & 32'hFFFF_FFFC;
      bus.pc_w = $urandom & 32'hFFFF_FFFC;
      bus.wc0   = ($urandom_range(0, 2) == 0);
      bus.wc0_n = 5'(11 + $urandom_range(0, 4));
      bus.wc0_d = $urandom;
      if ($urandom_range(0, 1) == 0)
        bus.wc0_d[5:0] = 6'h3F;
      bus.eret  = ($urandom_range(0, 4) == 0);
      bus.rc0_n = 5'(10 + $urandom_range(0, 5));
      cyc();
    end

    $display("Simulation finished: %0d checks, %0d errors",
             nchk, nerr);
    $finish;
  end

endmodule
